seven_segment_scan_controller: RTL and testbench
================================================

Name: seven_segment_scan_controller

Overview:
- Time-multiplexes DIGITS BCD digits onto one shared SevenSegment decoder and a common-segment multi-digit display.
- Holds a double-buffered digit word and scans one digit at a time, driving the 4-bit decoder input and a one-hot digit enable.
- Inserts a blanking gap between digits to stop ghosting.
- New values are committed only at frame boundaries, so a displayed frame never tears.

Parameters:
- DIGITS, 4, number of digit positions scanned (2..8).
- REFRESH_DIV, 50000, clock cycles each digit is lit (>=2).
- BLANK_CYCLES, 500, cycles all digit enables are low between digits (>=1, < REFRESH_DIV).
- LZ_BLANK, 1, when 1, leading zeros (most significant side) are blanked; digit 0 is always shown.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = scanning; 0 = display dark, scan position held at digit 0.
- load  in  1  one-cycle strobe; captures data_in into the pending buffer.
- data_in  in  4*DIGITS  BCD digits; nibble k = digit k, where digit 0 is the least significant / rightmost.
- load_ready  out  1  1 when no pending value awaits commit.
- bcd_out  out  4  nibble to the decoder inputs, inputA = bit3 ... inputD = bit0.
- digit_en  out  DIGITS  one-hot active-high digit enable; all zero when dark.
- frame_done  out  1  one-cycle pulse after the last digit's lit period ends.

Behaviour:
- One clock domain; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state = DARK, digit index = 0, counter = 0.
  - display buffer = 0, pending buffer = 0, pending flag = 0.
  - bcd_out = 0, digit_en = 0, frame_done = 0, load_ready = 1.
- States:
  - DARK: entered on reset, or whenever enable=0 (checked every cycle, in any state). Outputs digit_en=0, index=0, counter=0.
  - DARK -> GAP when enable=1.
  - GAP: digit_en=0 for BLANK_CYCLES cycles. bcd_out already presents the nibble for the current index. GAP -> SHOW.
  - SHOW: digit_en = 1<<index for REFRESH_DIV cycles.
  - At the end of SHOW: if index = DIGITS-1, then index -> 0 and frame_done pulses for 1 cycle in the first GAP cycle. Otherwise index -> index+1. Next state is GAP.
- Load handshake:
  - load=1 copies data_in to the pending buffer and sets the pending flag, regardless of state.
  - A second load before commit overwrites the pending buffer; last value wins, no error.
  - load_ready = ~pending flag, registered.
- Commit: pending buffer -> display buffer, pending flag cleared.
  - Occurs in the cycle frame_done is asserted, or on the DARK->GAP transition.
  - If load and commit happen in the same cycle, commit takes the old pending value, and the new value stays pending (flag stays 1).
- bcd_out:
  - Equals display-buffer nibble[index], registered, with one cycle latency from an index change.
  - Nibble values 10..15 are illegal to the decoder: bcd_out is forced to 0 and that digit's enable is suppressed (blank digit).
- Leading-zero blanking (LZ_BLANK=1): digit k > 0 is suppressed (enable low) if it and all higher digits are 0. Computed from the display buffer only.
- Scan timing: frame period = DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles. The counter width is clog2(max(REFRESH_DIV, BLANK_CYCLES)) and the counter resets at every state change.
- Exclusivity: digit_en is never more than one-hot, including the cycle of any state transition.
- Reset mid-frame: reset takes priority over load and enable; all outputs return to reset values next cycle and the pending value is lost.
- enable falling mid-SHOW: digit_en = 0 next cycle. The buffers are kept; the pending value commits at the next DARK->GAP transition.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless stated):
- Reset, then enable=1 -> digit_en sequence per frame is 0000,0001x4,0000,0010x4,0000,0100x4,0000,1000x4. frame_done pulses once every 20 cycles.
- load data_in=16'h1234 while dark, then enable=1 -> bcd_out is 4,3,2,1 while digits 0..3 are lit. load_ready returns to 1 after the first GAP cycle.
- load 16'h0007 mid-frame while showing 16'h1234 -> the current frame completes with 1234. The next frame shows 7 on digit 0 with digits 1..3 dark (LZ_BLANK). load_ready=0 until the frame_done cycle.
- data_in=16'h0A05 committed -> digit 2 is dark and bcd_out=0 in its slot; digit 1 (0) is shown because a higher digit is nonzero. No X on any output.
- Back-to-back loads 16'h1111 then 16'h2222 in the frame_done cycle -> 1111 is displayed this frame, 2222 next frame.
- Assert rst during the SHOW of digit 2 with a pending value -> next cycle digit_en=0, bcd_out=0, load_ready=1. Re-enabling shows 0 on digit 0 only.

Source files
------------

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed BCD scan driver for a common-segment multi-digit display.
// Double-buffered digit word, blanking gaps, frame-aligned commits.
module seven_segment_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic                  load_ready,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = $clog2(DIGITS);

    typedef enum logic [1:0] {DARK, GAP, SHOW} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [4*DIGITS-1:0] disp, disp_n, pend, pend_n;
    logic                pflag, pflag_n;
    logic                commit, fd_n;
    logic [3:0]          nib;
    logic                illegal, upper_nz, lz_sup;
    logic [DIGITS-1:0]   en_n;
    logic [3:0]          bcd_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        commit  = 1'b0;
        fd_n    = 1'b0;
        if (!enable) begin
            state_n = DARK;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                DARK: begin
                    state_n = GAP;
                    idx_n   = '0;
                    cnt_n   = '0;
                    commit  = 1'b1;
                end
                GAP: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == CW'(REFRESH_DIV - 1)) begin
                        state_n = GAP;
                        cnt_n   = '0;
                        if (idx == IW'(DIGITS - 1)) begin
                            idx_n  = '0;
                            fd_n   = 1'b1;
                            commit = 1'b1;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state_n = DARK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Commit reads the old pending word; a coincident load stays pending.
    always_comb begin
        disp_n  = commit ? pend : disp;
        pend_n  = load ? data_in : pend;
        pflag_n = load | (pflag & ~commit);
    end

    // Outputs are derived from next-cycle state so they land registered.
    always_comb begin
        nib      = disp_n[{idx_n, 2'b00} +: 4];
        illegal  = (nib > 4'd9);
        upper_nz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx_n) && disp_n[4*k +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        lz_sup = (LZ_BLANK != 0) && (idx_n != '0) && !upper_nz;
        en_n   = '0;
        if (state_n == SHOW && !illegal && !lz_sup) begin
            en_n = DIGITS'(1) << idx_n;
        end
        bcd_n = (state_n == DARK || illegal) ? 4'd0 : nib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DARK;
            idx        <= '0;
            cnt        <= '0;
            disp       <= '0;
            pend       <= '0;
            pflag      <= 1'b0;
            bcd_out    <= 4'd0;
            digit_en   <= '0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            disp       <= disp_n;
            pend       <= pend_n;
            pflag      <= pflag_n;
            bcd_out    <= bcd_n;
            digit_en   <= en_n;
            frame_done <= fd_n;
            load_ready <= ~pflag_n;
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench for the scan controller.
// Frame model predicts outputs; monitor compares.
module tb_seven_segment_scan_controller;
  localparam int D = 4;
  localparam int R = 4;
  localparam int B = 1;
  localparam int P = R + B;
  localparam int F = D * P;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           load = 1'b0;
  logic [4*D-1:0] data_in = '0;
  logic           load_ready;
  logic [3:0]     bcd_out;
  logic [D-1:0]   digit_en;
  logic           frame_done;

  seven_segment_scan_controller #(
    .DIGITS(D), .REFRESH_DIV(R),
    .BLANK_CYCLES(B), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst),
    .enable(enable), .load(load),
    .data_in(data_in),
    .load_ready(load_ready),
    .bcd_out(bcd_out),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         rdy;
    logic [3:0]   bcd;
    logic [D-1:0] en;
    logic         fd;
  } obs_t;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit             m_dark = 1;
  int             m_t = 0;
  logic [4*D-1:0] m_disp = '0;
  logic [4*D-1:0] m_pend = '0;
  bit             m_pflag = 0;

  always @(posedge clk) begin
    obs_t e;
    bit   cm;
    int   d;
    int   pos;
    int   nv;
    bit   lz;
    e  = '0;
    cm = 0;
    if (rst) begin
      m_dark = 1;
      m_disp = '0;
      m_pend = '0;
      m_pflag = 0;
      e.rdy = 1'b1;
    end else begin
      if (!enable) begin
        m_dark = 1;
      end else if (m_dark) begin
        m_dark = 0;
        m_t = 0;
        cm = 1;
      end else begin
        m_t = m_t + 1;
        cm = (m_t % F == 0);
      end
      if (cm) begin
        m_disp = m_pend;
        m_pflag = 0;
      end
      if (load) begin
        m_pend = data_in;
        m_pflag = 1;
      end
      e.rdy = !m_pflag;
      if (!m_dark) begin
        d   = (m_t / P) % D;
        pos = m_t % P;
        nv  = int'((m_disp >> (4 * d)) & 16'hF);
        lz  = (d > 0) &&
              ((m_disp >> (4 * d)) == 0);
        e.bcd = (nv > 9) ? 4'd0 : 4'(nv);
        if (pos >= B && nv <= 9 && !lz)
          e.en = D'(1) << d;
        e.fd = (m_t > 0) && (m_t % F == 0);
      end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{load_ready, bcd_out,
            digit_en, frame_done};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got %b want %b",
                 $time, a, e);
      end
    end
  end

  task automatic chk_rst();
    n_cmp++;
    if (digit_en !== '0 || bcd_out !== 4'd0 ||
        load_ready !== 1'b1 ||
        frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset t=%0t en=%b bcd=%h rdy=%b fd=%b",
               $time, digit_en, bcd_out,
               load_ready, frame_done);
    end
  endtask

  task automatic wait_fd(input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      load = 1'b0;
      rst  = 1'b0;
      if (frame_done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL timeout t=%0t no frame_done in %0d",
               $time, lim);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
      rst  = 1'b0;
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    @(negedge clk);
    rst = 1'b0;
    load = 1'b1;
    data_in = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic logic [4*D-1:0] rnd_word();
    logic [4*D-1:0] w;
    for (int k = 0; k < D; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)
        w[4*k +: 4] = 4'd0;
      else if (r < 8)
        w[4*k +: 4] = 4'($urandom_range(1, 9));
      else
        w[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  initial begin
    @(negedge clk);
    chk_rst();
    step(2);
    do_load(16'h1234);
    enable = 1'b1;
    step(2 * F + 3);
    wait_fd(F + 2);
    do_load(16'h0007);
    step(2 * F);
    do_load(16'h0A05);
    step(2 * F);
    do_load(16'h1111);
    do_load(16'h2222);
    step(3 * F);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(2 * P + 2);
    do_load(16'h9876);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_rst();
    step(2 * F);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 799) == 0);
      load = ($urandom_range(0, 24) == 0);
      if (load) data_in = rnd_word();
      if ($urandom_range(0, 299) == 0)
        enable = ~enable;
      if (!enable && $urandom_range(0, 7) == 0)
        enable = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
